// File: rtl/fpu_wb_queue.sv
// fpu_wb_queue: in-order FPU result buffer draining into the FP register-file write port.
// Optional FPU_WB_BYPASS_EN: an empty queue forwards a retirable beat combinationally.
module fpu_wb_queue #(
  parameter int DEPTH   = 8,
  parameter int FPU_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        in_wen,
  input  logic [3:0]  in_wdst,
  input  logic        in_wbank,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_flags,
  input  logic        rf_ready,
  output logic        rf_wen,
  output logic [3:0]  rf_wdst,
  output logic        rf_wbank,
  output logic [31:0] rf_wdata,
  output logic [4:0]  flag_set,
  output logic        flag_valid,
  output logic        almost_full,
  output logic [31:0] busy_mask,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, cnt, cnt_d;
  logic [AW-1:0] hd, wa, s;
  logic wen_q [DEPTH];
  logic bank_q [DEPTH];
  logic [3:0] dst_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [4:0] flags_q [DEPTH];
  logic empty, full, retire, byp, enq, nw, nb;
  logic [3:0] nd;
  logic almost_full_q, overflow_q;
  logic [31:0] busy_q, busy_d;
  assign hd = rd_q[AW-1:0];
  assign wa = wr_q[AW-1:0];
  assign cnt = wr_q - rd_q;
  assign empty = cnt == '0;
  assign full = cnt[AW];
  assign retire = !empty && !flush && (!wen_q[hd] || rf_ready);
`ifdef FPU_WB_BYPASS_EN
  assign byp = !rst && empty && in_valid && !flush && (!in_wen || rf_ready);
`else
  assign byp = 1'b0;
`endif
  // A retire frees the head slot first, so a full queue still accepts a beat
  assign enq = in_valid && !flush && !byp && (!full || retire);
  assign wr_d = flush ? '0 : wr_q + (AW+1)'(enq);
  assign rd_d = flush ? '0 : rd_q + (AW+1)'(retire);
  assign cnt_d = wr_d - rd_d;
  always_comb begin
    busy_d = '0;
    s = '0;
    nw = 1'b0;
    nb = 1'b0;
    nd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = rd_d[AW-1:0] + AW'(i);
      nw = (enq && s == wa) ? in_wen : wen_q[s];
      nb = (enq && s == wa) ? in_wbank : bank_q[s];
      nd = (enq && s == wa) ? in_wdst : dst_q[s];
      if ((AW+1)'(i) < cnt_d && nw) busy_d[{nb, nd}] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      almost_full_q <= 1'b0;
      busy_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      almost_full_q <= cnt_d > (AW+1)'(DEPTH - 1 - FPU_LAT);
      busy_q <= busy_d;
      if (in_valid && !flush && full && !retire) overflow_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      wen_q[wa] <= in_wen;
      bank_q[wa] <= in_wbank;
      dst_q[wa] <= in_wdst;
      data_q[wa] <= in_wdata;
      flags_q[wa] <= in_flags;
    end
  end
  assign rf_wen = retire ? wen_q[hd] : byp && in_wen;
  assign rf_wdst = retire ? dst_q[hd] : byp ? in_wdst : '0;
  assign rf_wbank = retire ? bank_q[hd] : byp && in_wbank;
  assign rf_wdata = retire ? data_q[hd] : byp ? in_wdata : '0;
  assign flag_set = retire ? flags_q[hd] : byp ? in_flags : '0;
  assign flag_valid = retire || byp;
  assign almost_full = almost_full_q;
  assign busy_mask = busy_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_fpu_wb_queue.sv
// tb_fpu_wb_queue: directed checks of ordering, backpressure, overflow, wen=0 retire, flush and reset.
module tb_fpu_wb_queue;
`ifdef FPU_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_wen = 1'b0, in_wbank = 1'b0, rf_ready = 1'b0;
  logic [3:0] in_wdst = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0] in_flags = '0;
  logic rf_wen, rf_wbank, flag_valid, almost_full, overflow;
  logic [3:0] rf_wdst;
  logic [31:0] rf_wdata, busy_mask;
  logic [4:0] flag_set;
  int total = 0, bad = 0;

  fpu_wb_queue #(.DEPTH(8), .FPU_LAT(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_wen(in_wen),
    .in_wdst(in_wdst), .in_wbank(in_wbank), .in_wdata(in_wdata), .in_flags(in_flags),
    .rf_ready(rf_ready), .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wbank(rf_wbank),
    .rf_wdata(rf_wdata), .flag_set(flag_set), .flag_valid(flag_valid),
    .almost_full(almost_full), .busy_mask(busy_mask), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic w, input logic b, input logic [3:0] d,
                      input logic [31:0] x, input logic [4:0] f);
    in_valid = v; in_wen = w; in_wbank = b; in_wdst = d; in_wdata = x; in_flags = f;
  endtask

  initial begin
    #12;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_flag_valid", flag_valid, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();
    // single beat, bank 1 dst 5
    rf_ready = 1'b1;
    beat(1, 1, 1, 5, 32'h3F800000, 0);
    #1 chk("single_enq_wen", rf_wen, 0);
    tick();
    beat(0, 0, 0, 0, 0, 0);
    #1 chk("single_wen", rf_wen, 1);
    chk("single_bank", rf_wbank, 1);
    chk("single_dst", rf_wdst, 5);
    chk("single_data", rf_wdata, 32'h3F800000);
    chk("single_fv", flag_valid, 1);
    chk("single_busy", busy_mask, 32'h0020_0000);
    tick();
    chk("single_busy_clr", busy_mask, 0);
    chk("single_idle", rf_wen, 0);
    // backpressure: 8 beats while the port is stalled
    rf_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(1, 1, 0, 4'(i), i, 0);
      tick();
      chk($sformatf("bp_af%0d", i), almost_full, (i + 1 >= 5));
    end
    beat(0, 0, 0, 0, 0, 0);
    #1 chk("bp_busy", busy_mask, 32'h0000_00FF);
    chk("bp_stall", rf_wen, 0);
    rf_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("bp_wen%0d", i), rf_wen, 1);
      chk($sformatf("bp_data%0d", i), rf_wdata, i);
      tick();
    end
    chk("bp_done", rf_wen, 0);
    chk("bp_ovf", overflow, 0);
    chk("bp_af_clr", almost_full, 0);
    // overflow: 9th beat into a full stalled queue is dropped
    rf_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(1, 1, 0, 4'(i), 32'h100 + i, 0);
      tick();
    end
    beat(1, 1, 0, 4'd9, 32'hDEAD, 0);
    #1 chk("ovf_stall", rf_wen, 0);
    tick();
    beat(0, 0, 0, 0, 0, 0);
    chk("ovf_set", overflow, 1);
    rf_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("ovf_data%0d", i), rf_wdata, 32'h100 + i);
      tick();
    end
    chk("ovf_no9th", rf_wen, 0);
    chk("ovf_sticky", overflow, 1);
    rst = 1'b1;
    #1 chk("ovf_rst", overflow, 0);
    rst = 1'b0;
    tick();
    // full queue, 9th beat coincides with a retire and is accepted
    rf_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat(1, 1, 0, 4'(i), 32'h200 + i, 0);
      tick();
    end
    beat(1, 1, 0, 4'd8, 32'h208, 0);
    rf_ready = 1'b1;
    #1 chk("full_ret_data", rf_wdata, 32'h200);
    chk("full_ret_wen", rf_wen, 1);
    tick();
    beat(0, 0, 0, 0, 0, 0);
    chk("full_ret_ovf", overflow, 0);
    for (int i = 1; i < 9; i++) begin
      #1 chk($sformatf("full_data%0d", i), rf_wdata, 32'h200 + i);
      tick();
    end
    chk("full_done", rf_wen, 0);
    // wen=0 head retires without the port
    rf_ready = 1'b0;
    beat(1, 0, 0, 3, 32'h1, 5'h10);
    tick();
    beat(1, 1, 0, 7, 32'hABC, 5'h01);
    #1 chk("cmp_fv", flag_valid, 1);
    chk("cmp_flags", flag_set, 5'h10);
    chk("cmp_wen", rf_wen, 0);
    chk("cmp_busy", busy_mask, 0);
    tick();
    beat(0, 0, 0, 0, 0, 0);
    #1 chk("wait_wen", rf_wen, 0);
    chk("wait_fv", flag_valid, 0);
    chk("wait_flags", flag_set, 0);
    chk("wait_busy", busy_mask, 32'h80);
    tick();
    chk("wait2_wen", rf_wen, 0);
    rf_ready = 1'b1;
    #1 chk("rel_wen", rf_wen, 1);
    chk("rel_data", rf_wdata, 32'hABC);
    chk("rel_flags", flag_set, 5'h01);
    tick();
    chk("rel_busy", busy_mask, 0);
    // flush with 3 entries and a same-cycle beat
    rf_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      beat(1, 1, 1, 4'(i), 32'h300 + i, 0);
      tick();
    end
    chk("fl_busy_pre", busy_mask, 32'h000E_0000);
    flush = 1'b1;
    rf_ready = 1'b1;
    beat(1, 1, 0, 9, 32'h399, 0);
    #1 chk("fl_wen", rf_wen, 0);
    chk("fl_fv", flag_valid, 0);
    tick();
    flush = 1'b0;
    beat(0, 0, 0, 0, 0, 0);
    #1 chk("fl_busy", busy_mask, 0);
    chk("fl_after_wen", rf_wen, 0);
    chk("fl_ovf", overflow, 0);
    rf_ready = 1'b0;
    beat(1, 1, 0, 4, 32'h55, 0);
    tick();
    beat(0, 0, 0, 0, 0, 0);
    rf_ready = 1'b1;
    #1 chk("fl_next_wen", rf_wen, 1);
    chk("fl_next_dst", rf_wdst, 4);
    chk("fl_next_data", rf_wdata, 32'h55);
    tick();
    // reset mid-drain
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(1, 1, 1, 4'(i), 32'h400 + i, 5'h02);
      tick();
    end
    beat(0, 0, 0, 0, 0, 0);
    rf_ready = 1'b1;
    #1 chk("rd_drain", rf_wen, 1);
    rst = 1'b1;
    #1 chk("rd_wen", rf_wen, 0);
    chk("rd_fv", flag_valid, 0);
    chk("rd_data", rf_wdata, 0);
    chk("rd_dst", rf_wdst, 0);
    chk("rd_bank", rf_wbank, 0);
    chk("rd_busy", busy_mask, 0);
    rst = 1'b0;
    tick();
    beat(1, 1, 0, 6, 32'h77, 0);
    #1 chk("post_rst_now", rf_wen, BYP);
    tick();
    beat(0, 0, 0, 0, 0, 0);
    #1 chk("post_rst_wen", rf_wen, !BYP);
    chk("post_rst_data", rf_wdata, BYP ? 32'h0 : 32'h77);
    tick();
    chk("post_rst_idle", rf_wen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_wb_queue.md
Name: fpu_wb_queue

Overview:
- Result buffer directly downstream of the FPU: captures every FPU result beat (out_valid/out_wen/out_wdst/out_wbank/out_wdata plus exception flags) in order and drains it into the shared FP register-file write port, which can be stalled by load/FMOV writes.
- Supplies an almost-full hint and a pending-destination mask, so issue stalls before the non-stallable FPU pipe can overflow the queue.
- Accumulates FPSCR flag bits in retirement order.

Parameters:
- DEPTH, 8: queue entries (power of 2, ≥ 2).
- FPU_LAT, 3: maximum FPU beats in flight after issue; sets the almost-full threshold.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous; discard all queued entries
- in_valid  in  1  FPU result beat
- in_wen  in  1  beat writes an FP register
- in_wdst  in  4  destination register
- in_wbank  in  1  destination bank
- in_wdata  in  32  result
- in_flags  in  5  exception flags of the beat {V,Z,O,U,I}
- rf_ready  in  1  register-file write port is free this cycle
- rf_wen  out  1  register-file write strobe
- rf_wdst  out  4  register-file write destination
- rf_wbank  out  1  register-file write bank
- rf_wdata  out  32  register-file write data
- flag_set  out  5  pulse: flags of the retiring entry, to be ORed into FPSCR
- flag_valid  out  1  flag_set qualifier
- almost_full  out  1  count > DEPTH-1-FPU_LAT; issue must hold FPU ops
- busy_mask  out  32  bit {bank,dst} set while any queued entry with wen=1 targets that register
- overflow  out  1  sticky: a beat was dropped because the queue was full

Behaviour:
- Reset (async, rst=1): queue empty, pointers and count 0, all outputs 0, overflow cleared.
- Storage: circular buffer of DEPTH entries {wen,wbank,wdst,wdata,flags}.
  - Read/write pointers are log2(DEPTH)+1 bits wide; the MSB disambiguates full from empty.
  - Pointers wrap modulo 2*DEPTH.
- Enqueue: on in_valid when not full; the beat is written at the write pointer at the clock edge.
  - in_valid while full: beat dropped, overflow set (sticky until rst), count unchanged.
- Head retire condition: queue non-empty, and either head.wen=0 or rf_ready=1.
- Retire outputs:
  - When the head retires, rf_wen = head.wen and rf_wdst/rf_wbank/rf_wdata = head fields.
  - Retire outputs are combinational from the head register; minimum enqueue-to-write latency is 1 cycle.
  - A head with wen=0 retires without the port: rf_wen=0, flag_valid=1.
  - When no entry retires: rf_wen=0, flag_valid=0, flag_set=0.
- Flags: flag_valid=1 on every retire; flag_set=head.flags. Flags are never merged across entries.
- Simultaneous enqueue and retire: allowed at any occupancy, including full. When full, the retire frees a slot first, so the beat is accepted; count unchanged.
- busy_mask: OR over valid entries with wen=1.
  - Updates the cycle after enqueue.
  - Clears in the cycle after the last matching entry retires.
- almost_full: registered from the next-state count.
- flush:
  - Pointers and count go to 0; a same-cycle in_valid is dropped without setting overflow.
  - No rf_wen or flag_valid in the flush cycle.
  - busy_mask is 0 the next cycle.
- rst asserted mid-drain: queue contents lost, outputs 0 immediately.

Optional Feature:
- FPU_WB_BYPASS_EN defined: when the queue is empty, in_valid=1, flush=0, and (in_wen=0 or rf_ready=1), the beat drives rf_*/flag_* combinationally in the same cycle and is not enqueued (0-cycle latency).
- Not defined: every beat is enqueued; minimum latency is 1 cycle.

Test Plan:
- Single beat: wen=1, bank=1, dst=5, data=0x3F800000, rf_ready=1 → cycle+1: rf_wen=1, rf_wbank=1, rf_wdst=5, rf_wdata=0x3F800000, flag_valid=1; busy_mask bit 21 high for exactly 1 cycle.
- Backpressure: rf_ready=0, 8 beats with data 0..7 → almost_full=1 after count reaches 5; release rf_ready → data 0..7 written in order; overflow stays 0.
- Overflow: full queue with rf_ready=0 plus a 9th beat → overflow=1; the 9th beat is never written. Same test with rf_ready=1 on that cycle → beat accepted, overflow=0.
- wen=0 head (compare beat, flags=0x10) with rf_ready=0 → retires next cycle: flag_valid=1, flag_set=0x10, rf_wen=0; the following wen=1 entry waits for rf_ready.
- flush with 3 entries queued plus a simultaneous in_valid → no rf_wen ever; busy_mask=0 next cycle; the next beat writes normally.
- rst pulse while draining → all outputs 0 asynchronously; after release, an empty queue accepts a new beat. With FPU_WB_BYPASS_EN: an empty queue plus rf_ready=1 writes in the same cycle.
